// File: rtl/apb_mem_pkg.sv
// Shared types and limits for the APB memory completer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    // Largest wait-state count the 4-bit wait counter can hold.
    localparam int MAX_WAIT = 15;

    // Address bits needed to index n words; never less than one bit.
    function automatic int addr_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// Byte-lane RAM: per-lane write enables, registered read on re, no reset.
// Latency: read data appears the cycle after re; writes land on the clock edge.
// Backpressure: none, accepts one read and one write per cycle.
module apb_mem_bank #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = 8,
    parameter int LANES = WIDTH / 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [LANES-1:0] be,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    input  logic             re,
    output logic [WIDTH-1:0] rdata
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rdata_q;

        // One byte column: strobed write, registered read.
        always_ff @(posedge clk) begin
            if (we && be[g]) begin
                mem[waddr] <= wdata[g*8 +: 8];
            end
            if (re) begin
                rdata_q <= mem[raddr];
            end
        end

        assign rdata[g*8 +: 8] = rdata_q;
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer fronting a byte-lane RAM with decode errors and wait states.
// Latency: 2+WAIT_STATES cycles per transfer; next setup accepted right after completion.
// Backpressure: pready held low for WAIT_STATES access cycles; dropping psel aborts.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(LANES);
    localparam int IDXW  = ADDR_WIDTH - LSB;
    localparam int AW    = addr_bits(MEM_DEPTH);

    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT) begin : g_bad_wait
        $error("apb_mem_slave: WAIT_STATES must be within 0..15");
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("apb_mem_slave: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (IDXW < AW) begin : g_bad_addr
        $error("apb_mem_slave: ADDR_WIDTH too narrow to reach MEM_DEPTH words");
    end

    // Address decode: word index plus range/alignment error.
    logic [IDXW-1:0] dec_idx;
    logic            dec_err;

    assign dec_idx = paddr[ADDR_WIDTH-1:LSB];
    assign dec_err = (32'(dec_idx) >= 32'(MEM_DEPTH))
                   || ((paddr & ADDR_WIDTH'(LANES - 1)) != '0);

    apb_state_t      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            err_q, err_d;
    logic            ram_re;
    logic            ram_we;
    logic [DATA_WIDTH-1:0] rdata;

    // Next-state: setup capture, wait countdown, commit or abort.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        err_d    = err_q;
        ram_re   = 1'b0;
        ram_we   = 1'b0;
        case (state_q)
            IDLE: begin
                // An access phase without a preceding setup is ignored here.
                if (psel && !penable) begin
                    state_d  = ACCESS;
                    pwrite_d = pwrite;
                    idx_d    = dec_idx[AW-1:0];
                    err_d    = dec_err;
                    cnt_d    = 4'(WAIT_STATES);
                    // Out-of-range indices never reach the RAM.
                    ram_re   = !dec_err;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (penable) begin
                    state_d = IDLE;
                    // Reset on the commit edge cancels the write.
                    ram_we  = pwrite_q && !err_q && !rst;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset returns to IDLE with the counter cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    apb_mem_bank #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_WIDTH),
        .AW    (AW),
        .LANES (LANES)
    ) u_bank (
        .clk   (clk),
        .we    (ram_we),
        .be    (pstrb),
        .waddr (idx_q),
        .wdata (pwdata),
        .raddr (dec_idx[AW-1:0]),
        .re    (ram_re),
        .rdata (rdata)
    );

    // Outputs decode from registered state only; no combinational path from inputs.
    always_comb begin
        pready  = (state_q == ACCESS) && (cnt_q == 4'd0);
        pslverr = pready && err_q;
        prdata  = (pready && !pwrite_q && !err_q) ? rdata : '0;
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

    logic        clk = 1'b0;
    logic        rst     [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [11:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];

    // Expected outputs for the current cycle, per instance.
    logic        exp_rdy [2];
    logic [31:0] exp_rd  [2];
    logic        exp_err [2];
    // Hand-computed literal pins for selected completion cycles.
    logic        lit_vld [2];
    logic [31:0] lit_rd  [2];
    logic        lit_err [2];
    logic        chk_en = 1'b0;

    // Reference memory contents, one image per instance.
    logic [31:0] mdl [2][256];

    int checks   = 0;
    int failures = 0;

    initial forever #5 clk = ~clk;

    apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

    apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    // Out of range (word 256+) or not word aligned.
    function automatic bit addr_err(input logic [11:0] a);
        return (int'(a[11:2]) >= 256) || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d t=%0t actual=%h required=%h", nm, i, $time, act, exp);
        end
    endtask

    // Single compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("pready", i, 32'(pready[i]), 32'(exp_rdy[i]));
                chk("pslverr", i, 32'(pslverr[i]), 32'(exp_err[i]));
                chk("prdata", i, prdata[i], exp_rd[i]);
                if (lit_vld[i]) begin
                    chk("lit_prdata", i, prdata[i], lit_rd[i]);
                    chk("lit_pslverr", i, 32'(pslverr[i]), 32'(lit_err[i]));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_zero(input int i);
        exp_rdy[i] = 1'b0;
        exp_err[i] = 1'b0;
        exp_rd[i]  = 32'h0;
        lit_vld[i] = 1'b0;
    endtask

    task automatic idle(input int i);
        psel[i]    = 1'b0;
        penable[i] = 1'b0;
        exp_zero(i);
        cyc();
    endtask

    // One full APB transfer; abort_k >= 0 drops psel in that access cycle.
    task automatic xfer(input int i, input bit wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int abort_k,
                        input bit lit_en, input logic [31:0] lit_d, input bit lit_e);
        bit e = addr_err(a);
        psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr;
        paddr[i] = a; pwdata[i] = d; pstrb[i] = s;
        exp_zero(i);
        cyc();
        for (int k = 0; k <= ws_of(i); k++) begin
            if (k == abort_k) begin
                psel[i] = 1'b0; penable[i] = 1'b0;
                exp_zero(i);
                cyc();
                return;
            end
            penable[i] = 1'b1;
            if (k == ws_of(i)) begin
                exp_rdy[i] = 1'b1;
                exp_err[i] = e;
                exp_rd[i]  = (!wr && !e) ? mdl[i][int'(a[11:2])] : 32'h0;
                lit_vld[i] = lit_en;
                lit_rd[i]  = lit_d;
                lit_err[i] = lit_e;
            end else begin
                exp_zero(i);
            end
            cyc();
        end
        if (wr && !e) mdl[i][int'(a[11:2])] = merge(mdl[i][int'(a[11:2])], d, s);
        exp_zero(i);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0;
            exp_zero(i);
            lit_rd[i] = '0; lit_err[i] = 1'b0;
        end
        cyc();
        chk_en = 1'b1;
        cyc();
        cyc();
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Known contents everywhere so the model never depends on power-up state.
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 256; w++)
                xfer(i, 1, 12'(w * 4), $urandom, 4'hF, -1, 0, 0, 0);
        idle(0); idle(1);

        // Zero wait states: full write then read.
        xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, -1, 1, 32'h0, 0);
        xfer(0, 0, 12'h010, 32'h0, 4'hF, -1, 1, 32'hDEADBEEF, 0);
        idle(0);

        // Byte strobes merge into the old word.
        xfer(0, 1, 12'h020, 32'hFFFFFFFF, 4'hF, -1, 0, 0, 0);
        xfer(0, 1, 12'h020, 32'h11223344, 4'b0101, -1, 0, 0, 0);
        xfer(0, 0, 12'h020, 32'h0, 4'hF, -1, 1, 32'hFF22FF44, 0);
        idle(0);

        // Decode errors: out of range and misaligned; RAM untouched.
        xfer(0, 0, 12'h400, 32'h0, 4'hF, -1, 1, 32'h0, 1);
        xfer(0, 1, 12'h000, 32'hA5A55A5A, 4'hF, -1, 0, 0, 0);
        xfer(0, 1, 12'h402, 32'h12345678, 4'hF, -1, 1, 32'h0, 1);
        xfer(0, 1, 12'h002, 32'h87654321, 4'hF, -1, 1, 32'h0, 1);
        xfer(0, 0, 12'h000, 32'h0, 4'hF, -1, 1, 32'hA5A55A5A, 0);
        idle(0);

        // Three wait states, back-to-back write then read.
        xfer(1, 1, 12'h030, 32'hCAFEF00D, 4'hF, -1, 1, 32'h0, 0);
        xfer(1, 0, 12'h030, 32'h0, 4'hF, -1, 1, 32'hCAFEF00D, 0);
        idle(1);

        // Abort mid-wait: no write.
        xfer(1, 1, 12'h034, 32'h12345678, 4'hF, -1, 0, 0, 0);
        xfer(1, 1, 12'h034, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 0);
        xfer(1, 0, 12'h034, 32'h0, 4'hF, -1, 1, 32'h12345678, 0);
        idle(1);

        // Reset during the wait phase, then a clean transfer follows.
        xfer(1, 1, 12'h040, 32'h0000BEEF, 4'hF, -1, 0, 0, 0);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h040;
        pwdata[1] = 32'h55555555; pstrb[1] = 4'hF; exp_zero(1); cyc();
        penable[1] = 1'b1; cyc();
        rst[1] = 1'b1; cyc();
        rst[1] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0; cyc();
        xfer(1, 0, 12'h040, 32'h0, 4'hF, -1, 1, 32'h0000BEEF, 0);
        idle(1);

        // Reset on the commit edge cancels the write.
        xfer(0, 1, 12'h044, 32'h00C0FFEE, 4'hF, -1, 0, 0, 0);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 12'h044;
        pwdata[0] = 32'h99999999; pstrb[0] = 4'hF; exp_zero(0); cyc();
        penable[0] = 1'b1; rst[0] = 1'b1;
        exp_rdy[0] = 1'b1; exp_err[0] = 1'b0; exp_rd[0] = 32'h0; cyc();
        rst[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0; exp_zero(0); cyc();
        xfer(0, 0, 12'h044, 32'h0, 4'hF, -1, 1, 32'h00C0FFEE, 0);
        idle(0);

        // Access phase with no setup is ignored; empty-strobe write is a no-op.
        xfer(0, 1, 12'h050, 32'h0BADC0DE, 4'hF, -1, 0, 0, 0);
        idle(0);
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 12'h050;
        pwdata[0] = 32'h0; pstrb[0] = 4'hF; exp_zero(0); cyc(); cyc();
        idle(0);
        xfer(0, 1, 12'h050, 32'h0, 4'h0, -1, 1, 32'h0, 0);
        xfer(0, 0, 12'h050, 32'h0, 4'hF, -1, 1, 32'h0BADC0DE, 0);
        idle(0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            int i = int'($urandom_range(0, 1));
            logic [11:0] a;
            int ab = -1;
            if ($urandom_range(0, 99) < 75) a = 12'($urandom_range(0, 255) * 4);
            else a = 12'($urandom);
            if (i == 1 && $urandom_range(0, 4) == 0) ab = int'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) begin
                psel[i] = 1'b1; penable[i] = 1'b1; pwrite[i] = 1'b1; paddr[i] = a;
                pwdata[i] = $urandom; pstrb[i] = 4'hF; exp_zero(i); cyc();
                idle(i);
            end
            xfer(i, 1'($urandom), a, $urandom, 4'($urandom), ab, 0, 0, 0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle(i);
        end

        idle(0); idle(1); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
